alu_seq: RTL

- Parametrised, sequential successor to the datapath's 4-bit AND/OR combinational ALU.
- WIDTH-bit operands, 8 operations: logic, add/sub, signed compare, and iterative shifts.
- Results and flags are registered.
- Sits between the register-read stage and writeback. Valid/ready handshakes on both the input and output sides let multi-cycle shifts stall the producer.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops; shifts iterate one bit per clock.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;
  logic [WIDTH-1:0] r_work;
  logic [SH_W-1:0]  r_count;
  logic             r_dir_right;

  logic             w_accept;
  logic [SH_W-1:0]  w_shamt;
  logic             w_is_shift;
  logic             w_start_shift;
  logic             w_shift_last;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic             w_less;
  logic [WIDTH-1:0] w_res;
  logic             w_res_carry;
  logic             w_res_ovf;
  logic [WIDTH-1:0] w_work_step;

  assign w_accept      = in_valid && (r_state == ST_IDLE);
  assign w_shamt       = b[SH_W-1:0];
  assign w_is_shift    = (ctrl == OP_SLL) || (ctrl == OP_SRL);
  assign w_start_shift = w_is_shift && (w_shamt != '0);
  assign w_shift_last  = (r_state == ST_SHIFT) && (r_count == SH_W'(1));

  // SUB and SLT share one adder: a + ~b + 1.
  assign w_sub     = (ctrl == OP_SUB) || (ctrl == OP_SLT);
  assign w_b_op    = w_sub ? ~b : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_b_op} + (WIDTH+1)'(w_sub);
  assign w_add_ovf = (a[WIDTH-1] == w_b_op[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != a[WIDTH-1]);
  // Sign of the difference corrected by overflow gives the true signed order.
  assign w_less    = w_sum[WIDTH-1] ^ w_add_ovf;

  always_comb begin
    w_res       = '0;
    w_res_carry = 1'b0;
    w_res_ovf   = 1'b0;
    case (ctrl)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_ADD, OP_SUB: begin
        w_res       = w_sum[WIDTH-1:0];
        w_res_carry = w_sum[WIDTH];
        w_res_ovf   = w_add_ovf;
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_less};
      OP_SLL, OP_SRL: w_res = a;
      default: w_res = '0;
    endcase
  end

  assign w_work_step = r_dir_right ? (r_work >> 1) : (r_work << 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_start_shift ? ST_SHIFT : ST_HOLD;
        end
      end
      ST_SHIFT: begin
        if (r_count == SH_W'(1)) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_work      <= '0;
      r_count     <= '0;
      r_dir_right <= 1'b0;
    end else if (w_accept) begin
      if (w_start_shift) begin
        r_work      <= a;
        r_count     <= w_shamt;
        r_dir_right <= ctrl[0];
      end else begin
        r_result   <= w_res;
        r_zero     <= (w_res == '0);
        r_carry    <= w_res_carry;
        r_overflow <= w_res_ovf;
      end
    end else if (r_state == ST_SHIFT) begin
      r_work  <= w_work_step;
      r_count <= r_count - SH_W'(1);
      if (w_shift_last) begin
        r_result   <= w_work_step;
        r_zero     <= (w_work_step == '0);
        r_carry    <= 1'b0;
        r_overflow <= 1'b0;
      end
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_overflow;

endmodule
